regfile_write_arbiter: RTL and testbench

Shares the single write port of the 16 x 32-bit register file between two writeback sources: requester 0 (ALU result) and requester 1 (memory load). Accepts at most one write per cycle through valid/ready handshakes with round-robin priority, and registers the winner onto the register-file write port. It also checks the decode-stage read addresses against the in-flight write, either flagging a hazard or forwarding the data, depending on build configuration.

---
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 tb/tb_regfile_write_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register-file write port with a read-after-write check.
// Define REGFILE_ARB_FWD_EN to forward the in-flight write instead of flagging a hazard.
module regfile_write_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              hazard_a,
    output logic              hazard_b
);
    logic              pri_q, pri_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              accept, match_a, match_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        req0_ready = !rst && !flush && req0_valid && (!req1_valid || !pri_q);
        req1_ready = !rst && !flush && req1_valid && (!req0_valid || pri_q);
        accept     = req0_ready || req1_ready;
        sel_addr   = req0_ready ? req0_addr : req1_addr;
        sel_data   = req0_ready ? req0_data : req1_data;
        // the pointer moves to the index that did not just win
        pri_d      = accept ? req0_ready : pri_q;
        rf_write_d = accept && (sel_addr != '0);
        rf_addr_d  = accept ? sel_addr : rf_addr_q;
        rf_data_d  = accept ? sel_data : rf_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q      <= 1'b0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            pri_q      <= pri_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign rf_write = rf_write_q;
    assign rf_addr  = rf_addr_q;
    assign rf_data  = rf_data_q;
    assign match_a  = rf_write_q && (rd_addr_a == rf_addr_q);
    assign match_b  = rf_write_q && (rd_addr_b == rf_addr_q);

`ifdef REGFILE_ARB_FWD_EN
    assign rd_data_a = match_a ? rf_data_q : rf_rdata_a;
    assign rd_data_b = match_b ? rf_data_q : rf_rdata_b;
    assign hazard_a  = 1'b0;
    assign hazard_b  = 1'b0;
`else
    assign rd_data_a = rf_rdata_a;
    assign rd_data_b = rf_rdata_b;
    assign hazard_a  = match_a && !rst;
    assign hazard_b  = match_b && !rst;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for regfile_write_arbiter (either REGFILE_ARB_FWD_EN build).
module tb_regfile_write_arbiter;
    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        rf_write;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic [31:0] rf_rdata_a = '0, rf_rdata_b = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        hazard_a, hazard_b;

    int n_checks = 0;
    int n_errors = 0;
    wr_t sb[$];
    logic        m_pri = 1'b0;
    logic        m_w = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f,
                        input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] a1, input logic [31:0] d1,
                        input logic [3:0] ra, input logic [3:0] rb);
        logic e0, e1, ma, mb;
        logic [3:0] aa;
        wr_t e;
        rst = r; flush = f;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rd_addr_a = ra; rd_addr_b = rb;
        rf_rdata_a = $urandom; rf_rdata_b = $urandom;
        #1;
        e0 = !r && !f && v0 && (!v1 || !m_pri);
        e1 = !r && !f && v1 && (!v0 || m_pri);
        check("req0_ready", 64'(req0_ready), 64'(e0));
        check("req1_ready", 64'(req1_ready), 64'(e1));
        ma = m_w && (ra == m_addr);
        mb = m_w && (rb == m_addr);
`ifdef REGFILE_ARB_FWD_EN
        check("rd_data_a", 64'(rd_data_a), 64'(ma ? m_data : rf_rdata_a));
        check("rd_data_b", 64'(rd_data_b), 64'(mb ? m_data : rf_rdata_b));
        check("hazard_a", 64'(hazard_a), 64'(0));
        check("hazard_b", 64'(hazard_b), 64'(0));
`else
        check("rd_data_a", 64'(rd_data_a), 64'(rf_rdata_a));
        check("rd_data_b", 64'(rd_data_b), 64'(rf_rdata_b));
        check("hazard_a", 64'(hazard_a), 64'(ma && !r));
        check("hazard_b", 64'(hazard_b), 64'(mb && !r));
`endif
        if (r) begin
            sb.push_back('{1'b0, 4'd0, 32'd0});
            m_pri = 1'b0;
        end else if (e0 || e1) begin
            aa = e0 ? a0 : a1;
            sb.push_back('{aa != 4'd0, aa, e0 ? d0 : d1});
            m_pri = e0;
        end else begin
            sb.push_back('{1'b0, m_addr, m_data});
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("rf_write", 64'(rf_write), 64'(e.w));
        check("rf_addr", 64'(rf_addr), 64'(e.a));
        check("rf_data", 64'(rf_data), 64'(e.d));
        m_w = e.w; m_addr = e.a; m_data = e.d;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 555, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 3);
        repeat (4) step(0, 0, 1, 3, 333, 1, 7, 777, 3, 7);
        step(0, 0, 0, 0, 0, 1, 0, 99, 0, 0);
        step(0, 0, 1, 4, 44, 0, 0, 0, 4, 4);
        step(0, 1, 0, 0, 0, 1, 9, 999, 4, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 4, 9);
        step(0, 0, 1, 1, 11, 1, 2, 22, 1, 2);
        step(0, 0, 1, 6, 66, 0, 0, 0, 6, 6);
        step(1, 0, 1, 8, 88, 1, 9, 99, 6, 6);
        step(0, 0, 1, 1, 11, 1, 2, 22, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 4'($urandom), $urandom,
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
